hub75_bcm_scheduler: RTL and testbench
======================================

// Module: hub75_bcm_scheduler
// PURPOSE
//  Sequences the HUB75 colour shifter for binary-coded-modulation refresh of a whole panel.
//  For each row address and each bit plane it requests one row shift, waits for latch completion, updates the panel row address, then drives OE low for a time weighted by 2^bit.
//  Sits between the frame-buffer memory/shifter pair and the panel connector.
// PARAMETERS
//  HPIXEL_P    64  panel width in pixels
//  VPIXEL_P    64  panel height in pixels
//  BPP_P       8   bits per colour channel (bit planes)
//  SEGMENTS_P  2   panel segments shifted in parallel; ROWS = VPIXEL_P/SEGMENTS_P
//  GUARD_P     4   blanking cycles before and after each OE window (>=1)
// PORTS
//  clk            in   1                          system clock
//  rst_n          in   1                          synchronous, active-low reset
//  i_enable       in   1                          run refresh while high
//  i_base_ticks   in   16                         OE-low cycles for bit plane 0 (0 treated as 1)
//  i_brightness   in   8                          global brightness (HUB75_BRIGHTNESS_EN only)
//  o_tx_start     out  1                          one-cycle shift request to colour shifter
//  o_init_addr    out  clog2(HPIXEL_P*VPIXEL_P)   first pixel address of row = row*HPIXEL_P
//  o_pix_bit      out  clog2(BPP_P)               bit plane to shift
//  i_tx_ready     in   1                          shifter idle (falls after start, rises after latch)
//  o_row_addr     out  clog2(ROWS)                panel row address A..E
//  o_oe_n         out  1                          panel output enable, active low
//  o_frame_start  out  1                          one-cycle pulse when row 0 bit 0 is requested
//  o_busy         out  1                          high whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except o_oe_n=1; state IDLE; row=0, bit=0; mid-operation reset aborts instantly.
//  States: IDLE, START, WAIT_BUSY, WAIT_DONE, GUARD_PRE, SHOW, GUARD_POST.
//  IDLE: if i_enable and i_tx_ready -> START.
//  START: o_tx_start=1 for exactly one cycle; o_init_addr/o_pix_bit valid that cycle and held until next START;
//   sample i_base_ticks; o_frame_start=1 same cycle if row==0 and bit==0 -> WAIT_BUSY.
//  WAIT_BUSY: wait for i_tx_ready==0 -> WAIT_DONE. WAIT_DONE: wait for i_tx_ready==1 -> GUARD_PRE.
//  o_oe_n=1 in all states except SHOW; o_row_addr updates only on WAIT_DONE->GUARD_PRE.
//  GUARD_PRE: GUARD_P cycles -> SHOW. SHOW: o_oe_n=0 for exactly max(base,1)<<bit cycles
//   (counter width 16+BPP_P, no overflow) -> GUARD_POST: GUARD_P cycles.
//  Advance on GUARD_POST exit: bit+1; bit==BPP_P-1 wraps to 0 and row+1; row==ROWS-1 wraps to 0.
//  After GUARD_POST: i_enable=1 -> START; else -> IDLE with row/bit reset to 0.
//  i_enable dropping mid-plane: current plane completes through GUARD_POST; never truncated.
//  i_tx_ready low in IDLE: wait, no start issued. Back-to-back START never occurs inside one plane.
//  Arithmetic: o_init_addr = row*HPIXEL_P, computed with full address width, no truncation.
// CONFIGURATION
//  HUB75_BRIGHTNESS_EN defined: SHOW window length unchanged; o_oe_n=0 only for first
//   (window*i_brightness)>>8 cycles of it (i_brightness sampled at START; 0 = dark, 255 ~ full).
//  Undefined: i_brightness ignored; o_oe_n=0 for the whole SHOW window.
// TESTING (HPIXEL_P=4, VPIXEL_P=4, SEGMENTS_P=2, BPP_P=2, GUARD_P=2; shifter model ready drops 1 cycle after start, rises 10 later)
//  Reset then enable=1, base=3 -> starts: (addr0,bit0),(0,1),(4,0),(4,1),(0,0); OE low runs 3,6,3,6 cycles.
//  Same run -> o_frame_start pulses only with (addr0,bit0) starts; row_addr 0,0,1,1 per plane, never changes with OE low.
//  Timing check -> OE falls exactly GUARD_P+1 cycles after ready rises; next start GUARD_P cycles after OE rises.
//  base=0 -> OE windows of 1 and 2 cycles; enable dropped during SHOW of bit1 -> window completes, IDLE, busy=0, row/bit=0.
//  rst_n low mid-SHOW -> next cycle oe_n=1, tx_start=0, row_addr=0, busy=0; re-enable restarts at addr0/bit0.
//  HUB75_BRIGHTNESS_EN, base=4, brightness=128 -> OE low 2 of 4 and 4 of 8 cycles; brightness=0 -> OE never low, period unchanged.

Source files
------------

// File: rtl/hub75_bcm_scheduler.sv
// hub75_bcm_scheduler: binary-coded-modulation refresh sequencer for a HUB75 panel.
// For every row and bit plane it requests one row shift from the colour shifter, waits for
// the latch to finish, updates the row address, then opens OE for max(base,1) << bit cycles,
// with GUARD_P blanking cycles on each side of the window.
// Optional feature: define HUB75_BRIGHTNESS_EN to scale the lit part of each window by
// i_brightness/256. The window length and refresh period stay the same.
`timescale 1ns/1ps
module hub75_bcm_scheduler #(
   parameter int unsigned HPIXEL_P   = 64,
   parameter int unsigned VPIXEL_P   = 64,
   parameter int unsigned BPP_P      = 8,
   parameter int unsigned SEGMENTS_P = 2,
   parameter int unsigned GUARD_P    = 4,
   localparam int unsigned Rows  = VPIXEL_P / SEGMENTS_P,
   localparam int unsigned AddrW = (HPIXEL_P * VPIXEL_P > 1) ? $clog2(HPIXEL_P * VPIXEL_P) : 1,
   localparam int unsigned BitW  = (BPP_P > 1) ? $clog2(BPP_P) : 1,
   localparam int unsigned RowW  = (Rows > 1) ? $clog2(Rows) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_enable,
   input  logic [15:0]      i_base_ticks,
   input  logic [7:0]       i_brightness,
   output logic             o_tx_start,
   output logic [AddrW-1:0] o_init_addr,
   output logic [BitW-1:0]  o_pix_bit,
   input  logic             i_tx_ready,
   output logic [RowW-1:0]  o_row_addr,
   output logic             o_oe_n,
   output logic             o_frame_start,
   output logic             o_busy
);

   // Wide enough for 0xFFFF << (BPP_P-1) without overflow.
   localparam int unsigned CntW = 16 + BPP_P;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StWaitBusy,
      StWaitDone,
      StGuardPre,
      StShow,
      StGuardPost
   } state_e;

   state_e           state_q, state_d;
   logic [RowW-1:0]  row_q, row_d;
   logic [BitW-1:0]  bit_q, bit_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [CntW-1:0]  window_q, window_next;
   logic [AddrW-1:0] addr_q;
   logic [BitW-1:0]  pix_bit_q;
   logic [RowW-1:0]  row_addr_q;
   logic [15:0]      base_eff;
   logic             enter_start;
   logic             oe_on;

`ifdef HUB75_BRIGHTNESS_EN
   logic [CntW-1:0]  lit_q, lit_next;
   logic [CntW+7:0]  lit_prod;
`else
   logic             unused_brightness;
   assign unused_brightness = ^i_brightness;
`endif

   // Window length for the plane being started; base of 0 behaves as 1.
   always_comb begin
      base_eff    = (i_base_ticks == 16'd0) ? 16'd1 : i_base_ticks;
      window_next = CntW'(base_eff) << bit_q;
`ifdef HUB75_BRIGHTNESS_EN
      lit_prod    = (CntW + 8)'(window_next) * (CntW + 8)'(i_brightness);
      lit_next    = lit_prod[CntW+7:8];
`endif
   end

   // Next-state logic: plane sequencing and row/bit advance on GUARD_POST exit.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      bit_d   = bit_q;
      unique case (state_q)
         StIdle: begin
            if (i_enable && i_tx_ready) state_d = StStart;
         end
         StStart: begin
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (!i_tx_ready) state_d = StWaitDone;
         end
         StWaitDone: begin
            if (i_tx_ready) state_d = StGuardPre;
         end
         StGuardPre: begin
            if (cnt_q == CntW'(GUARD_P - 1)) state_d = StShow;
         end
         StShow: begin
            if (cnt_q == window_q - CntW'(1)) state_d = StGuardPost;
         end
         StGuardPost: begin
            if (cnt_q == CntW'(GUARD_P - 1)) begin
               if (bit_q == BitW'(BPP_P - 1)) begin
                  bit_d = '0;
                  row_d = (row_q == RowW'(Rows - 1)) ? '0 : row_q + RowW'(1);
               end else begin
                  bit_d = bit_q + BitW'(1);
               end
               if (i_enable) begin
                  state_d = StStart;
               end else begin
                  // Stopping refresh rewinds to the top of the frame.
                  state_d = StIdle;
                  row_d   = '0;
                  bit_d   = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Cycle counter restarts on every state change; only the timed states use it.
   always_comb begin
      cnt_d = '0;
      if (state_d == state_q &&
          (state_q == StGuardPre || state_q == StShow || state_q == StGuardPost)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   assign enter_start = (state_d == StStart) && (state_q != StStart);

   // State, position and sampled-per-plane registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         row_q      <= '0;
         bit_q      <= '0;
         cnt_q      <= '0;
         window_q   <= CntW'(1);
         addr_q     <= '0;
         pix_bit_q  <= '0;
         row_addr_q <= '0;
`ifdef HUB75_BRIGHTNESS_EN
         lit_q      <= '0;
`endif
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         // Shift request fields are presented with the START cycle and held until the next one.
         if (enter_start) begin
            addr_q    <= AddrW'(row_d) * AddrW'(HPIXEL_P);
            pix_bit_q <= bit_d;
         end
         if (state_q == StStart) begin
            window_q <= window_next;
`ifdef HUB75_BRIGHTNESS_EN
            lit_q    <= lit_next;
`endif
         end
         // Row lines only move while the panel is blanked, after the new row has latched.
         if (state_q == StWaitDone && state_d == StGuardPre) begin
            row_addr_q <= row_q;
         end
      end
   end

   // OE is lit for the whole SHOW window, or only its leading part when brightness is scaled.
   always_comb begin
`ifdef HUB75_BRIGHTNESS_EN
      oe_on = (state_q == StShow) && (cnt_q < lit_q);
`else
      oe_on = (state_q == StShow);
`endif
   end

   assign o_tx_start    = (state_q == StStart);
   assign o_frame_start = (state_q == StStart) && (row_q == '0) && (bit_q == '0);
   assign o_init_addr   = addr_q;
   assign o_pix_bit     = pix_bit_q;
   assign o_row_addr    = row_addr_q;
   assign o_oe_n        = !oe_on;
   assign o_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Bench for hub75_bcm_scheduler: directed runs with a scoreboard of expected shift requests
// and OE windows, checked by a negedge monitor against a simple shifter model.
`timescale 1ns/1ps
module tb_hub75_bcm_scheduler;

   localparam int unsigned HPix  = 4;
   localparam int unsigned VPix  = 4;
   localparam int unsigned Bpp   = 2;
   localparam int unsigned Seg   = 2;
   localparam int unsigned Guard = 2;

   logic        clk;
   logic        rst_n;
   logic        i_enable;
   logic [15:0] i_base_ticks;
   logic [7:0]  i_brightness;
   logic        o_tx_start;
   logic [3:0]  o_init_addr;
   logic [0:0]  o_pix_bit;
   logic        i_tx_ready;
   logic [0:0]  o_row_addr;
   logic        o_oe_n;
   logic        o_frame_start;
   logic        o_busy;

   hub75_bcm_scheduler #(
      .HPIXEL_P  (HPix),
      .VPIXEL_P  (VPix),
      .BPP_P     (Bpp),
      .SEGMENTS_P(Seg),
      .GUARD_P   (Guard)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_enable     (i_enable),
      .i_base_ticks (i_base_ticks),
      .i_brightness (i_brightness),
      .o_tx_start   (o_tx_start),
      .o_init_addr  (o_init_addr),
      .o_pix_bit    (o_pix_bit),
      .i_tx_ready   (i_tx_ready),
      .o_row_addr   (o_row_addr),
      .o_oe_n       (o_oe_n),
      .o_frame_start(o_frame_start),
      .o_busy       (o_busy)
   );

   typedef struct {
      int addr;
      int pbit;
      int frame;
   } start_t;

   typedef struct {
      int len;
      int row;
   } oe_t;

   start_t exp_start[$];
   oe_t    exp_oe[$];
   int     errors = 0;
   int     checks = 0;
   bit     chk_gap = 1'b1;

   // Monitor bookkeeping.
   int     oe_run = 0;
   int     since_ready = 1000;
   int     since_oe = 1000;
   bit     gap_armed = 1'b0;
   logic   prev_oe_n = 1'b1;
   logic   prev_ready = 1'b1;
   logic [0:0] prev_row = '0;
   int     cyc = 0;
   int     last_start_cyc = 0;
   int     last_gap = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic push_start(input int addr, input int pbit, input int frame);
      start_t s;
      s.addr  = addr;
      s.pbit  = pbit;
      s.frame = frame;
      exp_start.push_back(s);
   endtask

   task automatic push_oe(input int len, input int row);
      oe_t o;
      o.len = len;
      o.row = row;
      exp_oe.push_back(o);
   endtask

   task automatic wait_starts(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (exp_start.size() == 0) break;
      end
      check(name, exp_start.size(), 0);
   endtask

   task automatic wait_idle(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (!o_busy) break;
      end
      check({name, "_busy"}, o_busy, 0);
      check({name, "_oe_n"}, o_oe_n, 1);
      check({name, "_oe_queue"}, exp_oe.size(), 0);
      check({name, "_start_queue"}, exp_start.size(), 0);
   endtask

   // Shifter model: ready drops one cycle after a start and rises ten cycles later.
   initial begin
      i_tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (o_tx_start === 1'b1) begin
            @(posedge clk);
            #1 i_tx_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1 i_tx_ready = 1'b1;
         end
      end
   end

   // Monitor: pops expectations as the DUT presents starts and OE windows.
   always @(negedge clk) begin
      if (!rst_n) begin
         // A window cut short by reset is dropped from the scoreboard.
         if (oe_run > 0 && exp_oe.size() > 0) void'(exp_oe.pop_front());
         oe_run     = 0;
         gap_armed  = 1'b0;
         prev_oe_n  = 1'b1;
         prev_ready = i_tx_ready;
         prev_row   = '0;
      end else begin
         cyc++;
         since_ready++;
         since_oe++;
         if (i_tx_ready && !prev_ready) since_ready = 0;

         if (!o_oe_n && prev_oe_n) begin
            check("oe_expected", exp_oe.size() > 0, 1);
            if (exp_oe.size() > 0) check("oe_row_addr", o_row_addr, exp_oe[0].row);
            check("oe_fall_after_ready", since_ready, Guard + 1);
         end
         if (!o_oe_n) begin
            if (!prev_oe_n) check("row_stable_oe_low", o_row_addr, prev_row);
            oe_run++;
         end
         if (o_oe_n && !prev_oe_n) begin
            if (exp_oe.size() > 0) begin
               oe_t e;
               e = exp_oe.pop_front();
               check("oe_len", oe_run, e.len);
            end
            oe_run    = 0;
            since_oe  = 0;
            gap_armed = chk_gap;
         end

         if (o_tx_start) begin
            check("start_expected", exp_start.size() > 0, 1);
            if (exp_start.size() > 0) begin
               start_t s;
               s = exp_start.pop_front();
               check("start_addr", o_init_addr, s.addr);
               check("start_bit", o_pix_bit, s.pbit);
               check("start_frame", o_frame_start, s.frame);
            end
            if (gap_armed) check("start_after_oe", since_oe, Guard);
            gap_armed      = 1'b0;
            last_gap       = cyc - last_start_cyc;
            last_start_cyc = cyc;
         end else if (o_frame_start) begin
            check("frame_without_start", o_frame_start, 0);
         end
         if (!o_busy) gap_armed = 1'b0;

         prev_oe_n  = o_oe_n;
         prev_ready = i_tx_ready;
         prev_row   = o_row_addr;
      end
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got %0d errors", errors);
      $fatal(1, "timeout");
   end

   initial begin
      bit found;
      rst_n        = 1'b0;
      i_enable     = 1'b0;
      i_base_ticks = 16'd3;
      i_brightness = 8'd255;

      // Reset values.
      repeat (3) @(negedge clk);
      #1;
      check("rst_oe_n", o_oe_n, 1);
      check("rst_tx_start", o_tx_start, 0);
      check("rst_frame_start", o_frame_start, 0);
      check("rst_busy", o_busy, 0);
      check("rst_row_addr", o_row_addr, 0);
      check("rst_init_addr", o_init_addr, 0);
      check("rst_pix_bit", o_pix_bit, 0);
      rst_n = 1'b1;

      // Main run: base 3, two rows of two planes, then wrap to the frame start.
      push_start(0, 0, 1); push_start(0, 1, 0); push_start(4, 0, 0);
      push_start(4, 1, 0); push_start(0, 0, 1);
      push_oe(3, 0); push_oe(6, 0); push_oe(3, 1); push_oe(6, 1); push_oe(3, 0);
      i_enable = 1'b1;
      wait_starts(300, "main_starts");
      // 16 fixed cycles per plane plus the 6-cycle window of the previous plane.
      check("main_period", last_gap, 22);
      i_enable = 1'b0;
      wait_idle(100, "main_idle");

      // Base 0 acts as 1; drop enable inside the bit-1 window.
      i_base_ticks = 16'd0;
      push_start(0, 0, 1); push_start(0, 1, 0);
      push_oe(1, 0); push_oe(2, 0);
      i_enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (!o_oe_n && o_pix_bit == 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("base0_reach_bit1_show", found, 1);
      i_enable = 1'b0;
      wait_idle(100, "base0_idle");

      // Reset during the row-1 window, then restart from the frame top.
      i_base_ticks = 16'd3;
      push_start(0, 0, 1); push_start(0, 1, 0); push_start(4, 0, 0);
      push_oe(3, 0); push_oe(6, 0); push_oe(3, 1);
      i_enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         if (!o_oe_n && o_init_addr == 4'd4) begin
            found = 1'b1;
            break;
         end
      end
      check("rst_mid_reach_show", found, 1);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("rst_mid_oe_n", o_oe_n, 1);
      check("rst_mid_tx_start", o_tx_start, 0);
      check("rst_mid_row_addr", o_row_addr, 0);
      check("rst_mid_busy", o_busy, 0);
      check("rst_mid_oe_queue", exp_oe.size(), 0);
      push_start(0, 0, 1);
      push_oe(3, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_starts(100, "restart_starts");
      i_enable = 1'b0;
      wait_idle(100, "restart_idle");

`ifdef HUB75_BRIGHTNESS_EN
      // Half brightness: lit for half of each window, blanking gaps no longer fixed.
      chk_gap      = 1'b0;
      i_base_ticks = 16'd4;
      i_brightness = 8'd128;
      push_start(0, 0, 1); push_start(0, 1, 0);
      push_oe(2, 0); push_oe(4, 0);
      i_enable = 1'b1;
      wait_starts(200, "bright128_starts");
      i_enable = 1'b0;
      wait_idle(100, "bright128_idle");

      // Zero brightness: panel stays dark but plane timing is unchanged.
      i_brightness = 8'd0;
      push_start(0, 0, 1); push_start(0, 1, 0);
      i_enable = 1'b1;
      wait_starts(200, "bright0_starts");
      i_enable = 1'b0;
      check("bright0_period", last_gap, 20);
      wait_idle(100, "bright0_idle");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
